game_board_mover: RTL and testbench

- Sequences one full 2048 move over a 4x4 board of 4-bit log2 tile codes, where 0 means empty.
- Extracts each of the 4 rows or columns in turn and drives it to an external combinational row push/merge unit, then writes the returned line back into a working board.
- Sits between the game controller (input decode) and the push/merge stage.
- Reports the new board, whether anything moved, and whether the win tile was produced.

---
 rtl/game_board_mover.sv | 126 ++++++++++++
 tb/tb_game_board_mover.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_board_mover.sv
// Sequences one 2048 move: feeds each of the four rows/columns of the latched board
// to an external push/merge unit and assembles the returned lines into the result board.
module game_board_mover #(
    parameter logic [3:0] WIN_TILE = 4'd11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_dir,
    input  logic [63:0] i_board_in,
    output logic [15:0] o_merge_row,
    output logic        o_merge_push_right,
    input  logic [15:0] i_merge_result,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_board_out,
    output logic        o_moved,
    output logic        o_win,
    output logic        o_dbg_state
);

    // Handshake: i_start is a one-cycle request honoured only while idle (o_busy=0);
    // o_done pulses for one cycle when o_board_out/o_moved/o_win take new values.
    typedef enum logic {S_IDLE = 1'b0, S_PROC = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_idx;
    logic [1:0]  r_dir;
    logic [63:0] r_orig;
    logic [63:0] r_work;
    logic [63:0] r_board_out;
    logic        r_moved;
    logic        r_win;
    logic        r_done;
    logic [15:0] w_line;
    logic [63:0] w_next_work;
    logic        w_win;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next_state = S_PROC;
            S_PROC: if (r_idx == 2'd3) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // dir[1] selects columns: nibble k of line idx is cell (k,idx) instead of (idx,k).
    always_comb begin
        w_line = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_dir[1]) begin
                w_line[k*4 +: 4] = r_orig[(k*4 + int'(r_idx))*4 +: 4];
            end else begin
                w_line[k*4 +: 4] = r_orig[(int'(r_idx)*4 + k)*4 +: 4];
            end
        end
    end

    always_comb begin
        w_next_work = r_work;
        for (int k = 0; k < 4; k++) begin
            if (r_dir[1]) begin
                w_next_work[(k*4 + int'(r_idx))*4 +: 4] = i_merge_result[k*4 +: 4];
            end else begin
                w_next_work[(int'(r_idx)*4 + k)*4 +: 4] = i_merge_result[k*4 +: 4];
            end
        end
    end

    always_comb begin
        w_win = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w_next_work[i*4 +: 4] == WIN_TILE) w_win = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx       <= 2'd0;
            r_dir       <= 2'd0;
            r_orig      <= '0;
            r_work      <= '0;
            r_board_out <= '0;
            r_moved     <= 1'b0;
            r_win       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                r_orig <= i_board_in;
                r_work <= i_board_in;
                r_dir  <= i_dir;
                r_idx  <= 2'd0;
            end else if (r_state == S_PROC) begin
                r_work <= w_next_work;
                r_idx  <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_board_out <= w_next_work;
                    r_moved     <= (w_next_work != r_orig);
                    r_win       <= w_win;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign o_merge_row        = (r_state == S_PROC) ? w_line : 16'h0000;
    assign o_merge_push_right = (r_state == S_PROC) & r_dir[0];
    assign o_busy             = (r_state == S_PROC);
    assign o_done             = r_done;
    assign o_board_out        = r_board_out;
    assign o_moved            = r_moved;
    assign o_win              = r_win;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_game_board_mover.sv
// Randomised and directed bench for game_board_mover with a behavioural 2048 move model
// and a queue-based scoreboard checked whenever the DUT pulses done.
module tb_game_board_mover;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_dir;
    logic [63:0] i_board_in;
    logic [15:0] o_merge_row;
    logic        o_merge_push_right;
    logic [15:0] i_merge_result;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_board_out;
    logic        o_moved;
    logic        o_win;
    logic        o_dbg_state;

    int checks = 0;
    int failures = 0;
    logic [65:0] exp_q[$];

    game_board_mover #(.WIN_TILE(4'd11)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_dir(i_dir),
        .i_board_in(i_board_in),
        .o_merge_row(o_merge_row),
        .o_merge_push_right(o_merge_push_right),
        .i_merge_result(i_merge_result),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_board_out(o_board_out),
        .o_moved(o_moved),
        .o_win(o_win),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Standard 2048 line push/merge: slide toward the push side, each tile merges once.
    function automatic logic [15:0] line_merge(input logic [15:0] line, input logic right);
        int t[4];
        int o[4];
        int n;
        int m;
        int i;
        int src;
        logic [15:0] res;
        n = 0;
        m = 0;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            src = right ? 3 - k : k;
            o[k] = 0;
            t[k] = 0;
            if (line[src*4 +: 4] != 4'd0) begin
                t[n] = int'(line[src*4 +: 4]);
                n++;
            end
        end
        i = 0;
        while (i < n) begin
            if (i + 1 < n && t[i] == t[i+1]) begin
                o[m] = (t[i] >= 15) ? 15 : t[i] + 1;
                i += 2;
            end else begin
                o[m] = t[i];
                i += 1;
            end
            m++;
        end
        for (int k = 0; k < 4; k++) begin
            src = right ? 3 - k : k;
            res[src*4 +: 4] = 4'(o[k]);
        end
        return res;
    endfunction

    function automatic logic [63:0] move_board(input logic [63:0] b, input logic [1:0] d);
        logic [3:0] g[4][4];
        logic [15:0] ln;
        logic [15:0] rs;
        logic [63:0] nb;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = b[(r*4 + c)*4 +: 4];
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 4; k++) ln[k*4 +: 4] = d[1] ? g[k][l] : g[l][k];
            rs = line_merge(ln, d[0]);
            for (int k = 0; k < 4; k++) begin
                if (d[1]) g[k][l] = rs[k*4 +: 4];
                else      g[l][k] = rs[k*4 +: 4];
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                nb[(r*4 + c)*4 +: 4] = g[r][c];
        return nb;
    endfunction

    function automatic logic [65:0] expect_move(input logic [63:0] b, input logic [1:0] d);
        logic [63:0] nb;
        logic w;
        nb = move_board(b, d);
        w = 1'b0;
        for (int i = 0; i < 16; i++) if (nb[i*4 +: 4] == 4'd11) w = 1'b1;
        return {w, (nb != b), nb};
    endfunction

    // External push/merge unit modelled combinationally.
    always_comb i_merge_result = line_merge(o_merge_row, o_merge_push_right);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!i_rst && o_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending move");
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                check("board_out", o_board_out, e[63:0]);
                check("moved", 64'(o_moved), 64'(e[64]));
                check("win", 64'(o_win), 64'(e[65]));
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 of the move.
    task automatic issue(input logic [63:0] b, input logic [1:0] d, input logic [65:0] e);
        i_start = 1'b1;
        i_board_in = b;
        i_dir = d;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_board_in = {$urandom, $urandom};
        i_dir = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input int start_cyc, input int exp_cyc);
        int n;
        n = start_cyc;
        while (!o_done && n < 15) begin
            @(negedge clk);
            n++;
        end
        check("done_cycle", 64'(n), 64'(exp_cyc));
    endtask

    initial begin
        int done_cnt;
        logic [63:0] b;
        logic [1:0] d;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_dir = 2'd0;
        i_board_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_board_out", o_board_out, 64'd0);
        check("rst_moved", 64'(o_moved), 64'd0);
        check("rst_win", 64'(o_win), 64'd0);
        i_rst = 1'b0;
        @(negedge clk);
        check("idle_merge_row", 64'(o_merge_row), 64'd0);
        check("idle_push_right", 64'(o_merge_push_right), 64'd0);

        // Reset in cycle 3 of a move: nothing completes.
        i_start = 1'b1;
        i_board_in = 64'h0000_0000_0000_2211;
        i_dir = 2'd0;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_board_out", o_board_out, 64'd0);
        check("midrst_moved", 64'(o_moved), 64'd0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);

        // Row left / right.
        issue(64'h0000_0000_0000_2211, 2'd0, {1'b0, 1'b1, 64'h0000_0000_0000_0032});
        check("left_busy", 64'(o_busy), 64'd1);
        check("left_push_right", 64'(o_merge_push_right), 64'd0);
        wait_done(1, 5);
        @(negedge clk);
        issue(64'h0000_0000_0000_2211, 2'd1, {1'b0, 1'b1, 64'h0000_0000_0000_3200});
        check("right_push_right", 64'(o_merge_push_right), 64'd1);
        wait_done(1, 5);
        @(negedge clk);

        // Columns up / down.
        issue(64'h0000_0001_0000_0001, 2'd2, {1'b0, 1'b1, 64'h0000_0000_0000_0002});
        check("up_merge_row0", 64'(o_merge_row), 64'h0101);
        check("up_push_right", 64'(o_merge_push_right), 64'd0);
        wait_done(1, 5);
        @(negedge clk);
        issue(64'h0000_0001_0000_0001, 2'd3, {1'b0, 1'b1, 64'h0002_0000_0000_0000});
        check("down_merge_row0", 64'(o_merge_row), 64'h0101);
        check("down_push_right", 64'(o_merge_push_right), 64'd1);
        wait_done(1, 5);
        @(negedge clk);

        // No move, plus a start pulse while busy that must be ignored.
        issue(64'h0000_0000_0000_4321, 2'd0, {1'b0, 1'b0, 64'h0000_0000_0000_4321});
        @(negedge clk);
        i_start = 1'b1;
        i_board_in = 64'h0000_0000_0000_2211;
        i_dir = 2'd1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        wait_done(3, 5);
        done_cnt = 0;
        repeat (7) begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
        check("ignored_start_no_done", 64'(done_cnt), 64'd0);

        // Win tile, then back-to-back start in the done cycle.
        issue(64'h0000_0000_0000_00AA, 2'd0, {1'b1, 1'b1, 64'h0000_0000_0000_000B});
        wait_done(1, 5);
        issue(64'h0000_0000_0000_000B, 2'd1, {1'b1, 1'b1, 64'h0000_0000_0000_B000});
        wait_done(1, 5);
        @(negedge clk);

        // Empty board.
        issue(64'd0, 2'($urandom_range(0, 3)), {1'b0, 1'b0, 64'd0});
        wait_done(1, 5);
        @(negedge clk);

        // Random boards and directions, with random idle gaps (0 = back-to-back).
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: b[i*4 +: 4] = 4'd0;
                    4, 5, 6:    b[i*4 +: 4] = 4'($urandom_range(1, 3));
                    7:          b[i*4 +: 4] = 4'($urandom_range(4, 9));
                    8:          b[i*4 +: 4] = 4'd10;
                    default:    b[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd11 : 4'd15;
                endcase
            end
            d = 2'($urandom_range(0, 3));
            issue(b, d, expect_move(b, d));
            check("rand_push_right", 64'(o_merge_push_right), 64'(d[0]));
            wait_done(1, 5);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
